// File: rtl/score_combo_ctrl.sv
// Score / combo tracker for the rhythm-game status display.
// Judge codes are edge-detected into hit events. Combo and max combo update
// on the event edge. Score is accumulated by a serial BCD adder that handles
// one digit per cycle, with a 1-entry pending buffer for overlapping events.
module score_combo_ctrl #(
  parameter int unsigned PTS_PERFECT = 5,
  parameter int unsigned PTS_GOOD    = 3,
  parameter int unsigned PTS_BAD     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  i_judge,
  input  logic        i_miss,
  input  logic        i_game_start,
  output logic [15:0] o_score_bcd,
  output logic [11:0] o_combo_bcd,
  output logic [11:0] o_max_combo_bcd,
  output logic        o_score_valid,
  output logic        o_busy,
  output logic        o_overflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADD0, S_ADD1, S_ADD2, S_ADD3, S_COMMIT
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  judge_prev_q, judge_prev_d;
  logic [15:0] score_q, score_d;
  logic [15:0] work_q, work_d;
  logic [3:0]  addend_q, addend_d;
  logic        carry_q, carry_d;
  logic [11:0] combo_q, combo_d;
  logic [11:0] max_q, max_d;
  logic        pend_vld_q, pend_vld_d;
  logic [1:0]  pend_code_q, pend_code_d;
  logic        overflow_q, overflow_d;
  logic        valid_q, valid_d;

  logic        hit;
  logic        start;
  logic        take_hit;
  logic [1:0]  start_code;
  logic [4:0]  dsum;
  logic [11:0] combo_hit;

  // One BCD digit add: returns {carry_out, digit}.
  function automatic logic [4:0] bcd_add_digit(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       cin);
    logic [4:0] s;
    logic [4:0] adj;
    s   = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    adj = s - 5'd10;
    if (s > 5'd9) return {1'b1, adj[3:0]};
    else          return {1'b0, s[3:0]};
  endfunction

  // Three-digit BCD increment that sticks at 999.
  function automatic logic [11:0] bcd3_inc_sat(input logic [11:0] v);
    logic [4:0] d0, d1, d2;
    if (v == 12'h999) return v;
    d0 = bcd_add_digit(v[3:0],  4'd1, 1'b0);
    d1 = bcd_add_digit(v[7:4],  4'd0, d0[4]);
    d2 = bcd_add_digit(v[11:8], 4'd0, d1[4]);
    return {d2[3:0], d1[3:0], d0[3:0]};
  endfunction

  // Points awarded for a judge code.
  function automatic logic [3:0] pts_of(input logic [1:0] code);
    case (code)
      2'b11:   return 4'(PTS_PERFECT);
      2'b10:   return 4'(PTS_GOOD);
      2'b01:   return 4'(PTS_BAD);
      default: return 4'd0;
    endcase
  endfunction

  assign hit = (i_judge != 2'b00) && (i_judge != judge_prev_q);

  // Next-state logic: event detection, combo tracking, serial score adder.
  always_comb begin
    state_d      = state_q;
    judge_prev_d = i_judge;
    score_d      = score_q;
    work_d       = work_q;
    addend_d     = addend_q;
    carry_d      = carry_q;
    pend_vld_d   = pend_vld_q;
    pend_code_d  = pend_code_q;
    overflow_d   = overflow_q;
    valid_d      = 1'b0;
    start        = 1'b0;
    take_hit     = 1'b0;
    start_code   = 2'b00;
    dsum         = 5'd0;

    // Hit first, then miss; max combo sees the post-hit value.
    combo_hit = combo_q;
    if (hit) combo_hit = i_judge[1] ? bcd3_inc_sat(combo_q) : 12'h000;
    max_d   = (combo_hit > max_q) ? combo_hit : max_q;
    combo_d = i_miss ? 12'h000 : combo_hit;

    case (state_q)
      S_IDLE: begin
        if (pend_vld_q) begin
          start      = 1'b1;
          start_code = pend_code_q;
          pend_vld_d = 1'b0;
        end else if (hit) begin
          start      = 1'b1;
          start_code = i_judge;
          take_hit   = 1'b1;
        end
      end
      S_ADD0: begin
        dsum        = bcd_add_digit(work_q[3:0], addend_q, carry_q);
        work_d[3:0] = dsum[3:0];
        carry_d     = dsum[4];
        state_d     = S_ADD1;
      end
      S_ADD1: begin
        dsum        = bcd_add_digit(work_q[7:4], 4'd0, carry_q);
        work_d[7:4] = dsum[3:0];
        carry_d     = dsum[4];
        state_d     = S_ADD2;
      end
      S_ADD2: begin
        dsum         = bcd_add_digit(work_q[11:8], 4'd0, carry_q);
        work_d[11:8] = dsum[3:0];
        carry_d      = dsum[4];
        state_d      = S_ADD3;
      end
      S_ADD3: begin
        dsum          = bcd_add_digit(work_q[15:12], 4'd0, carry_q);
        work_d[15:12] = dsum[3:0];
        carry_d       = dsum[4];
        state_d       = S_COMMIT;
      end
      S_COMMIT: begin
        score_d = carry_q ? 16'h9999 : work_q;
        valid_d = 1'b1;
        carry_d = 1'b0;
        state_d = S_IDLE;
        if (pend_vld_q) begin
          start      = 1'b1;
          start_code = pend_code_q;
          pend_vld_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Starting an add works from the score as it will stand after this edge.
    if (start) begin
      work_d   = score_d;
      addend_d = pts_of(start_code);
      carry_d  = 1'b0;
      state_d  = S_ADD0;
    end

    // Hits not started directly are buffered once, then dropped.
    if (hit && !take_hit) begin
      if (!pend_vld_q) begin
        pend_vld_d  = 1'b1;
        pend_code_d = i_judge;
      end else begin
        overflow_d = 1'b1;
      end
    end

    // New song clears everything and discards same-cycle events.
    if (i_game_start) begin
      state_d     = S_IDLE;
      score_d     = 16'h0000;
      work_d      = 16'h0000;
      carry_d     = 1'b0;
      combo_d     = 12'h000;
      max_d       = 12'h000;
      pend_vld_d  = 1'b0;
      pend_code_d = 2'b00;
      overflow_d  = 1'b0;
      valid_d     = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      judge_prev_q <= 2'b00;
      score_q      <= 16'h0000;
      work_q       <= 16'h0000;
      addend_q     <= 4'd0;
      carry_q      <= 1'b0;
      combo_q      <= 12'h000;
      max_q        <= 12'h000;
      pend_vld_q   <= 1'b0;
      pend_code_q  <= 2'b00;
      overflow_q   <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      judge_prev_q <= judge_prev_d;
      score_q      <= score_d;
      work_q       <= work_d;
      addend_q     <= addend_d;
      carry_q      <= carry_d;
      combo_q      <= combo_d;
      max_q        <= max_d;
      pend_vld_q   <= pend_vld_d;
      pend_code_q  <= pend_code_d;
      overflow_q   <= overflow_d;
      valid_q      <= valid_d;
    end
  end

  assign o_score_bcd     = score_q;
  assign o_combo_bcd     = combo_q;
  assign o_max_combo_bcd = max_q;
  assign o_score_valid   = valid_q;
  assign o_busy          = (state_q != S_IDLE);
  assign o_overflow      = overflow_q;

endmodule

// File: tb/tb_score_combo_ctrl.sv
// Directed testbench for score_combo_ctrl.
module tb_score_combo_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  i_judge;
  logic        i_miss;
  logic        i_game_start;
  logic [15:0] o_score_bcd;
  logic [11:0] o_combo_bcd;
  logic [11:0] o_max_combo_bcd;
  logic        o_score_valid;
  logic        o_busy;
  logic        o_overflow;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  score_combo_ctrl #(
    .PTS_PERFECT(5),
    .PTS_GOOD(3),
    .PTS_BAD(1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_judge         (i_judge),
    .i_miss          (i_miss),
    .i_game_start    (i_game_start),
    .o_score_bcd     (o_score_bcd),
    .o_combo_bcd     (o_combo_bcd),
    .o_max_combo_bcd (o_max_combo_bcd),
    .o_score_valid   (o_score_valid),
    .o_busy          (o_busy),
    .o_overflow      (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One distinct judge event, then idle long enough for the add to finish.
  task automatic send(input logic [1:0] code);
    @(negedge clk) i_judge = code;
    @(negedge clk) i_judge = 2'b00;
    repeat (6) @(negedge clk);
  endtask

  task automatic game_start();
    @(negedge clk) i_game_start = 1'b1;
    @(negedge clk) i_game_start = 1'b0;
  endtask

  int vcnt;
  int vat;

  initial begin
    rst = 1'b0; i_judge = 2'b00; i_miss = 1'b0; i_game_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_score",    o_score_bcd, 16'h0000);
    chk("rst_combo",    16'(o_combo_bcd), 16'h0000);
    chk("rst_max",      16'(o_max_combo_bcd), 16'h0000);
    chk("rst_valid",    16'(o_score_valid), 16'h0000);
    chk("rst_busy",     16'(o_busy), 16'h0000);
    chk("rst_overflow", 16'(o_overflow), 16'h0000);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Test 1: held Perfect counts once; valid 5 cycles after the event edge.
    i_judge = 2'b11;
    vcnt = 0; vat = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) chk("t1_busy", 16'(o_busy), 16'h0001);
      if (o_score_valid) begin vcnt++; vat = c; end
    end
    i_judge = 2'b00;
    chk("t1_vcnt",  16'(vcnt), 16'd1);
    chk("t1_vat",   16'(vat),  16'd6);
    chk("t1_score", o_score_bcd, 16'h0005);
    chk("t1_combo", 16'(o_combo_bcd), 16'h0001);
    chk("t1_max",   16'(o_max_combo_bcd), 16'h0001);

    // Test 2: Perfect, Good, Bad.
    game_start();
    chk("t2_clr", o_score_bcd, 16'h0000);
    @(negedge clk) i_judge = 2'b11;
    @(negedge clk) i_judge = 2'b00;
    repeat (19) @(negedge clk);
    chk("t2_score_p", o_score_bcd, 16'h0005);
    chk("t2_combo_p", 16'(o_combo_bcd), 16'h0001);
    @(negedge clk) i_judge = 2'b10;
    @(negedge clk) i_judge = 2'b00;
    repeat (19) @(negedge clk);
    chk("t2_score_g", o_score_bcd, 16'h0008);
    chk("t2_combo_g", 16'(o_combo_bcd), 16'h0002);
    @(negedge clk) i_judge = 2'b01;
    @(negedge clk) i_judge = 2'b00;
    repeat (19) @(negedge clk);
    chk("t2_score_b", o_score_bcd, 16'h0009);
    chk("t2_combo_b", 16'(o_combo_bcd), 16'h0000);
    chk("t2_max",     16'(o_max_combo_bcd), 16'h0002);

    // Test 3: climb to 9997 (also saturates combo at 999), then saturate score.
    game_start();
    send(2'b01);
    send(2'b01);
    for (int n = 0; n < 1999; n++) send(2'b11);
    chk("t3_score_9997", o_score_bcd, 16'h9997);
    chk("t3_combo_999",  16'(o_combo_bcd), 16'h0999);
    chk("t3_max_999",    16'(o_max_combo_bcd), 16'h0999);
    send(2'b11);
    chk("t3_score_sat",  o_score_bcd, 16'h9999);
    chk("t3_combo_sat",  16'(o_combo_bcd), 16'h0999);
    send(2'b10);
    chk("t3_score_sat2", o_score_bcd, 16'h9999);

    // Test 4: three back-to-back events: add, pend, drop.
    game_start();
    send(2'b11);
    chk("t4_pre", o_score_bcd, 16'h0005);
    chk("t4_pre_ovf", 16'(o_overflow), 16'h0000);
    @(negedge clk) i_judge = 2'b11;
    @(negedge clk) i_judge = 2'b10;
    @(negedge clk) i_judge = 2'b11;
    @(negedge clk) i_judge = 2'b00;
    repeat (20) @(negedge clk);
    chk("t4_score", o_score_bcd, 16'h0013);
    chk("t4_combo", 16'(o_combo_bcd), 16'h0004);
    chk("t4_max",   16'(o_max_combo_bcd), 16'h0004);
    chk("t4_ovf",   16'(o_overflow), 16'h0001);
    chk("t4_busy",  16'(o_busy), 16'h0000);

    // Test 5: miss with a Perfect at combo 41.
    game_start();
    chk("t5_ovf_clr", 16'(o_overflow), 16'h0000);
    for (int n = 0; n < 41; n++) send(2'b11);
    chk("t5_combo41", 16'(o_combo_bcd), 16'h0041);
    chk("t5_score205", o_score_bcd, 16'h0205);
    @(negedge clk) begin i_judge = 2'b11; i_miss = 1'b1; end
    @(negedge clk) begin i_judge = 2'b00; i_miss = 1'b0; end
    repeat (8) @(negedge clk);
    chk("t5_combo", 16'(o_combo_bcd), 16'h0000);
    chk("t5_max",   16'(o_max_combo_bcd), 16'h0042);
    chk("t5_score", o_score_bcd, 16'h0210);

    // Test 6: game start during ADD2 aborts the add.
    @(negedge clk) i_judge = 2'b11;
    @(negedge clk) i_judge = 2'b00;
    chk("t6_busy_pre",  16'(o_busy), 16'h0001);
    chk("t6_combo_pre", 16'(o_combo_bcd), 16'h0001);
    @(negedge clk);
    @(negedge clk) i_game_start = 1'b1;
    @(negedge clk) i_game_start = 1'b0;
    chk("t6_score", o_score_bcd, 16'h0000);
    chk("t6_combo", 16'(o_combo_bcd), 16'h0000);
    chk("t6_max",   16'(o_max_combo_bcd), 16'h0000);
    chk("t6_busy",  16'(o_busy), 16'h0000);
    chk("t6_valid", 16'(o_score_valid), 16'h0000);
    vcnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_score_valid) vcnt++;
    end
    chk("t6_no_valid", 16'(vcnt), 16'd0);
    chk("t6_score_after", o_score_bcd, 16'h0000);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/score_combo_ctrl.md
Name: score_combo_ctrl

Overview:
Downstream consumer of the judgement controller's 2-bit judge code. It also takes a miss pulse from the LCD note scroller. The block keeps a 4-digit BCD score, a 3-digit BCD current combo and a 3-digit BCD max combo for the 7-segment/LCD status display. Score accumulation uses a serial, one-digit-per-cycle BCD adder, with a 1-entry pending buffer for events that arrive while an add is in progress.

Parameters:
PTS_PERFECT, 5, points added for judge 2'b11 (legal range 0-9)
PTS_GOOD, 3, points added for judge 2'b10 (legal range 0-9)
PTS_BAD, 1, points added for judge 2'b01 (legal range 0-9)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
i_judge  in  2  judge code; 00 = none, 01 = Bad, 10 = Good, 11 = Perfect; held for up to 1 ms
i_miss  in  1  1-cycle pulse: a note left the hit zone unhit
i_game_start  in  1  1-cycle pulse: clear all counters for a new song
o_score_bcd  out  16  score, 4 BCD digits, [3:0] = ones digit
o_combo_bcd  out  12  current combo, 3 BCD digits
o_max_combo_bcd  out  12  highest combo since the last game start
o_score_valid  out  1  1-cycle pulse when o_score_bcd commits a new value
o_busy  out  1  serial adder active
o_overflow  out  1  sticky flag: a judge event was dropped

Behaviour:
- Reset (rst = 0, asynchronous):
  - All outputs, judge_prev, the pending buffer and the FSM go to 0 / IDLE.
- Event detection:
  - Register judge_prev <= i_judge every cycle.
  - A hit event fires at edge E when i_judge != 0 and i_judge != judge_prev.
  - A code held for many cycles counts once. A direct change between two nonzero codes counts as a new event.
- Combo (updated at edge E, no FSM involvement):
  - Perfect or Good: combo += 1, saturating at 999.
  - Bad: combo <= 0.
  - i_miss: combo <= 0.
  - Hit and miss on the same edge: apply the hit first, then the miss. Final combo = 0; max combo still sees the incremented value.
  - max_combo <= max(max_combo, new combo) at the same edge.
- Score FSM states: IDLE, ADD0, ADD1, ADD2, ADD3, COMMIT.
  - IDLE with an event at E (or a pending entry): load work <= o_score_bcd and the addend from the judge code; go to ADD0; o_busy = 1 after E.
  - ADDk (one cycle each): work digit k <= BCD sum of digit k + (k == 0 ? addend : 0) + carry; carry is registered.
  - COMMIT: if the carry out of ADD3 is 1, o_score_bcd <= 16'h9999 (saturate); else o_score_bcd <= work. o_score_valid pulses for 1 cycle.
  - From COMMIT: go to ADD0 with the pending entry if one exists (pending cleared), else IDLE.
  - Latency: event edge E -> new score and o_score_valid visible after edge E+5. o_busy is high from after E through COMMIT.
- Pending buffer:
  - An event arriving while the FSM is not IDLE is stored in a 1-entry pending register (code only).
  - An event arriving while pending is full is dropped for the score only (combo is still updated); o_overflow <= 1 (sticky).
  - An event in the COMMIT cycle with pending empty goes to pending.
- i_game_start (synchronous, highest priority):
  - Clears score, combo, max combo, pending, o_overflow, o_score_valid, the carry and the FSM to IDLE, aborting any add in progress.
  - Any hit or miss event in the same cycle is ignored.
  - judge_prev still updates, so a held code does not re-fire afterwards.
- BCD invariant: no output digit ever exceeds 9.

Test Plan:
1. Reset released, i_judge = 11 held 100 cycles -> exactly one event; combo = 001, max = 001; o_score_bcd = 0005 with a single o_score_valid 5 cycles after the rising edge of i_judge.
2. Judges 11, 10, 01 spaced 20 cycles apart -> score 0005, 0008, 0009; combo 1, 2, 0; max combo 002.
3. Score preloaded to 9997 via repeated hits, then a Perfect -> o_score_bcd = 9999 (saturated), no wrap to 0002.
4. Three distinct judge events on consecutive cycles (11 -> 10 -> 11) -> first is added, second goes to pending, third is dropped with o_overflow = 1; final score = prior + 8; combo increments by 3.
5. i_miss coincident with a Perfect event at combo 041 -> combo 000, max combo 042, score + 5.
6. i_game_start asserted in ADD2 of an add -> next cycle all counters 0, o_busy = 0, no o_score_valid; combo after 999 Perfects stays at 999.
